gf_power_table: RTL
===================

GF_POWER_TABLE -- requirements
Module: gf_power_table

Interface
REQ-001 SHALL have parameter M, default 8, meaning the field width; legal values are 3..8, giving GF(2^M).
REQ-002 SHALL have parameter PRIM_POLY, default 9'h11D, meaning the primitive polynomial, M+1 bits wide with bit M set.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port init_start, input, 1 bit: a one-cycle pulse requesting a table rebuild.
REQ-006 SHALL have port ready_o, output, 1 bit: high when the tables are valid.
REQ-007 SHALL have port req_valid, input, 1 bit: a lookup request.
REQ-008 SHALL have port req_ready, output, 1 bit: the request is accepted when req_valid && req_ready.
REQ-009 SHALL have port req_mode, input, 1 bit: 0 = exp (alpha^addr), 1 = log.
REQ-010 SHALL have port req_addr, input, M bits: the exponent (exp mode) or the field element (log mode).
REQ-011 SHALL have port rsp_valid, output, 1 bit: a one-cycle response strobe.
REQ-012 SHALL have port rsp_data, output, M bits: the lookup result.
REQ-013 SHALL have port rsp_err, output, 1 bit: set for log(0).

Function
REQ-014 SHALL contain two internal tables of 2^M entries by M bits: EXP and LOG.
REQ-015 SHALL implement FSM states INIT and READY; states SHALL be encoded so that no unreachable state persists.
REQ-016 SHALL enter INIT on the first rising edge after rst_n deasserts.
REQ-017 INIT SHALL use a counter i = 0..2^M-2 and a register lfsr starting at 1.
REQ-018 Each INIT cycle SHALL write EXP[i]=lfsr and LOG[lfsr]=i, then update lfsr = (lfsr<<1) ^ (lfsr[M-1] ? PRIM_POLY[M-1:0] : 0).
REQ-019 INIT SHALL last exactly 2^M-1 cycles; the state SHALL be READY, with ready_o=1, on the edge after the write for i=2^M-2.
REQ-020 req_ready SHALL equal (state==READY), registered, and SHALL never be asserted during INIT.
REQ-021 An accepted request SHALL produce rsp_valid=1 on the next edge, giving 1-cycle latency; rsp_valid SHALL be 0 otherwise; the response has no backpressure.
REQ-022 Exp mode: for addr < 2^M-1, rsp_data=EXP[addr]; for addr = 2^M-1, rsp_data=EXP[0]=1 (wrap, alpha^(2^M-1)=1); rsp_err=0.
REQ-023 Exp mode back-to-back requests SHALL be accepted every cycle, giving throughput of 1 per clock.
REQ-024 Log mode: for addr != 0, rsp_data=LOG[addr] and rsp_err=0; for addr = 0, rsp_data=0 and rsp_err=1.
REQ-025 rsp_data and rsp_err SHALL hold their last value when rsp_valid=0.
REQ-026 init_start in READY SHALL restart INIT (i=0, lfsr=1) on that edge; ready_o and req_ready SHALL drop on the same edge.
REQ-027 A request presented in the same cycle as init_start SHALL be accepted and answered from the old tables.
REQ-028 init_start during INIT SHALL be ignored.

Reset
REQ-029 While rst_n=0: ready_o=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, i=0, lfsr=1, and the FSM is held ahead of INIT.
REQ-030 Reset asserted mid-INIT or mid-transaction SHALL discard all progress; table contents need not be cleared, since a full rebuild follows.

Configuration
REQ-031 Macro GF_POWER_TABLE_LOG_EN SHALL control the log path.
REQ-032 With GF_POWER_TABLE_LOG_EN defined, the LOG table, log mode and rsp_err SHALL exist as specified above.
REQ-033 Without GF_POWER_TABLE_LOG_EN: no LOG storage; req_mode is ignored and every request is exp mode; rsp_err is tied to 0; INIT length is unchanged.

Verification
REQ-034 Default parameters, release reset -> ready_o rises exactly 255 edges after the first edge following rst_n release; req_ready=0 throughout INIT.
REQ-035 Exp addr 0,8,25,254,255 -> rsp_data 0x01,0x1D,0x03,0x8E,0x01, each one cycle after acceptance; back-to-back streaming at one request per cycle.
REQ-036 Log (LOG_EN defined) addr 0x1D,0x8E,0x01,0x00 -> rsp_data 8,254,0,0 with rsp_err 0,0,0,1.
REQ-037 M=4, PRIM_POLY=5'h13 -> ready after 15 edges; exp 4 -> 0x3; exp 15 -> 0x1; log 0x9 -> 14.
REQ-038 init_start pulsed with a simultaneous request in READY -> that request answered, ready_o low for 255 cycles, then a rebuilt table identical to the first build; an init_start pulse during INIT does not extend INIT.
REQ-039 rst_n asserted at INIT cycle 100 -> all outputs 0 immediately; after release, a full 255-cycle INIT runs and all 255 EXP entries match the golden GF(256) table.

Source files
------------

// File: rtl/gf_power_table.sv
// GF(2^M) power/log lookup tables, rebuilt by an LFSR walk after reset or on request.
// Define GF_POWER_TABLE_LOG_EN to build the LOG table, log-mode lookups and rsp_err.
module gf_power_table #(
    parameter int         M         = 8,
    parameter logic [M:0] PRIM_POLY = 9'h11D
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init_start,
    output logic         ready_o,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic [M-1:0] req_addr,
    output logic         rsp_valid,
    output logic [M-1:0] rsp_data,
    output logic         rsp_err
);

    localparam int DEPTH = 1 << M;

    // S_IDLE is the post-reset holding state; the unused encoding falls back to it.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam logic [M-1:0] ONE      = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M-1:0] LAST_IDX = {{(M-1){1'b1}}, 1'b0};

    logic [1:0]   r_state;
    logic [M-1:0] r_idx;
    logic [M-1:0] r_lfsr;
    logic [M-1:0] r_exp [DEPTH];

    logic         r_rsp_valid;
    logic [M-1:0] r_rsp_data;

    logic [M-1:0] w_lfsr_next;
    logic         w_init_go;
    logic         w_init_last;
    logic         w_accept;
    logic [M-1:0] w_exp_idx;
    logic [M-1:0] w_rd_data;

    assign w_lfsr_next = {r_lfsr[M-2:0], 1'b0} ^ (r_lfsr[M-1] ? PRIM_POLY[M-1:0] : '0);
    assign w_init_go   = (r_state == S_INIT);
    assign w_init_last = w_init_go && (r_idx == LAST_IDX);

    assign ready_o   = (r_state == S_READY);
    assign req_ready = (r_state == S_READY);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_lfsr  <= ONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_INIT;
                end
                S_INIT: begin
                    if (w_init_last) begin
                        r_state <= S_READY;
                        r_idx   <= '0;
                        r_lfsr  <= ONE;
                    end else begin
                        r_idx   <= r_idx + ONE;
                        r_lfsr  <= w_lfsr_next;
                    end
                end
                S_READY: begin
                    if (init_start) begin
                        r_state <= S_INIT;
                        r_idx   <= '0;
                        r_lfsr  <= ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_lfsr  <= ONE;
                end
            endcase
        end
    end

    // NOTE: table storage has no reset; every reset is followed by a full rebuild,
    // and a reset port would stop the arrays mapping onto RAM.
    always_ff @(posedge clk) begin
        if (w_init_go) begin
            r_exp[r_idx] <= r_lfsr;
        end
    end

    // alpha^(2^M-1) wraps to alpha^0; that entry is never written.
    assign w_exp_idx = (req_addr == '1) ? '0 : req_addr;

`ifdef GF_POWER_TABLE_LOG_EN
    logic [M-1:0] r_log [DEPTH];
    logic         r_rsp_err;
    logic         w_rd_err;

    always_ff @(posedge clk) begin
        if (w_init_go) begin
            r_log[r_lfsr] <= r_idx;
        end
    end

    always_comb begin
        w_rd_data = r_exp[w_exp_idx];
        w_rd_err  = 1'b0;
        if (req_mode) begin
            if (req_addr == '0) begin
                w_rd_data = '0;
                w_rd_err  = 1'b1;
            end else begin
                w_rd_data = r_log[req_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err <= w_rd_err;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    // Without the log path every request is an exp lookup.
    logic w_unused_mode;

    assign w_unused_mode = req_mode;
    assign w_rd_data     = r_exp[w_exp_idx];
    assign rsp_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_data <= w_rd_data;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
